// File: rtl/ring_buffer_monitor.sv
// Passive checker for the DDR2 read-capture ring: shadows writes, checks dout against readPtr.
// Optional RING_BUFFER_MONITOR_LOG_EN adds simulation-only $display logging.
module ring_buffer_monitor #(
  parameter int DATA_W = 16,
  parameter int PTR_W  = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              listen,
  input  logic              strobe,
  input  logic [DATA_W-1:0] din,
  input  logic [PTR_W-1:0]  readPtr,
  input  logic [DATA_W-1:0] dout,
  output logic              mismatch,
  output logic [DATA_W-1:0] exp_data,
  output logic [PTR_W-1:0]  err_ptr,
  output logic [CNT_W-1:0]  error_count,
  output logic [CNT_W-1:0]  write_count
);
  localparam int DEPTH = 1 << PTR_W;

  logic [DATA_W-1:0] model [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic [PTR_W-1:0]  wptr;
  logic              wr;
  logic [DATA_W-1:0] exp_cur;
  logic              fail;

  assign wr      = listen && strobe;
  assign exp_cur = model[readPtr];
  // Case inequality flags X/Z on dout in simulation; synthesizes as plain !=.
  assign fail    = valid[readPtr] && (dout !== exp_cur);

  // Shadow data is not reset; valid bits gate every compare.
  always_ff @(posedge clk) begin
    if (!reset && wr) model[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr        <= '0;
      valid       <= '0;
      mismatch    <= 1'b0;
      exp_data    <= '0;
      err_ptr     <= '0;
      error_count <= '0;
      write_count <= '0;
    end else begin
      if (wr) begin
        valid[wptr] <= 1'b1;
        wptr        <= wptr + PTR_W'(1);
        if (write_count != '1) write_count <= write_count + CNT_W'(1);
      end
      mismatch <= fail;
      if (fail) begin
        exp_data <= exp_cur;
        err_ptr  <= readPtr;
        if (error_count != '1) error_count <= error_count + CNT_W'(1);
      end
    end
  end

`ifdef RING_BUFFER_MONITOR_LOG_EN
  always @(posedge clk) begin
    if (reset)
      $display("%0t ring monitor reset", $time);
    else if (fail)
      $display("%0t ring monitor: readPtr=%0d expected=%h actual=%h", $time, readPtr, exp_cur, dout);
  end
`endif

endmodule

// File: tb/tb_ring_buffer_monitor.sv
// Self-checking bench for ring_buffer_monitor: directed plan steps plus a randomized phase
// against an array-based reference of the ring.
module tb_ring_buffer_monitor;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        listen = 1'b0, strobe = 1'b0;
  logic [15:0] din = '0, dout = '0;
  logic [2:0]  readPtr = '0;
  logic        mismatch;
  logic [15:0] exp_data, error_count, write_count;
  logic [2:0]  err_ptr;

  int tests = 0, fails = 0;

  // Reference state
  logic [15:0] mem [8];
  bit          vld [8];
  int          wp, ec, wc;
  bit          e_mis;
  logic [15:0] e_exp;
  logic [2:0]  e_ptr;

  ring_buffer_monitor #(.DATA_W(16), .PTR_W(3), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .listen(listen), .strobe(strobe), .din(din),
    .readPtr(readPtr), .dout(dout), .mismatch(mismatch), .exp_data(exp_data),
    .err_ptr(err_ptr), .error_count(error_count), .write_count(write_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] cur(input logic [2:0] rp);
    return mem[rp];
  endfunction

  // One clock: apply inputs, advance reference on the edge, check all outputs just after.
  task automatic cyc(input bit r, input bit l, input bit s, input logic [15:0] d,
                     input logic [2:0] rp, input logic [15:0] dt);
    bit f;
    reset = r; listen = l; strobe = s; din = d; readPtr = rp; dout = dt;
    @(posedge clk);
    if (r) begin
      wp = 0; ec = 0; wc = 0; e_mis = 0; e_exp = '0; e_ptr = '0;
      foreach (vld[i]) vld[i] = 0;
    end else begin
      f = vld[rp] && (dt != mem[rp]);
      e_mis = f;
      if (f) begin
        e_exp = mem[rp]; e_ptr = rp;
        if (ec < 65535) ec++;
      end
      if (l && s) begin
        mem[wp] = d; vld[wp] = 1; wp = (wp + 1) % 8;
        if (wc < 65535) wc++;
      end
    end
    #1;
    chk("mismatch", {31'd0, mismatch}, {31'd0, e_mis});
    chk("error_count", {16'd0, error_count}, ec);
    chk("write_count", {16'd0, write_count}, wc);
    chk("exp_data", {16'd0, exp_data}, {16'd0, e_exp});
    chk("err_ptr", {29'd0, err_ptr}, {29'd0, e_ptr});
  endtask

  task automatic wr(input logic [15:0] d);
    cyc(0, 1, 1, d, 3'd0, cur(3'd0));
  endtask

  task automatic rd(input logic [2:0] rp, input logic [15:0] dt);
    cyc(0, 0, 0, 16'h0, rp, dt);
  endtask

  initial begin
    foreach (mem[i]) mem[i] = '0;
    // Reset then idle sweep with arbitrary dout
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("reset_mismatch", {31'd0, mismatch}, 0);
    chk("reset_wcount", {16'd0, write_count}, 0);
    for (int i = 0; i < 8; i++) rd(3'(i), 16'($urandom));
    chk("idle_ecount", {16'd0, error_count}, 0);

    // Capture 8 words
    for (int i = 1; i <= 8; i++) wr(16'(i * 16'h1111));
    rd(3'd3, 16'h4444);
    chk("cap_wcount", {16'd0, write_count}, 8);
    chk("cap_nomis", {31'd0, mismatch}, 0);

    // Wrong read at entry 5
    rd(3'd5, 16'hDEAD);
    chk("err_mis", {31'd0, mismatch}, 1);
    chk("err_exp", {16'd0, exp_data}, 32'h6666);
    chk("err_ptr5", {29'd0, err_ptr}, 5);
    chk("err_cnt", {16'd0, error_count}, 1);
    rd(3'd5, 16'h6666);
    chk("err_clear", {31'd0, mismatch}, 0);

    // Wrap-around
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) wr(16'(i));
    rd(3'd0, 16'h0009); chk("wrap_e0", {31'd0, mismatch}, 0);
    rd(3'd1, 16'h000A); chk("wrap_e1", {31'd0, mismatch}, 0);
    rd(3'd2, 16'h0003); chk("wrap_e2", {31'd0, mismatch}, 0);
    rd(3'd0, 16'h0001);
    chk("wrap_err", {31'd0, mismatch}, 1);
    chk("wrap_exp", {16'd0, exp_data}, 32'h0009);

    // Strobe without listen, then same-cycle write+read of entry 2
    cyc(0, 0, 1, 16'hFFFF, 3'd0, 16'h0009);
    chk("nolisten_wc", {16'd0, write_count}, 10);
    chk("nolisten_e0", {31'd0, mismatch}, 0);
    cyc(0, 1, 1, 16'h5555, 3'd2, 16'h0003);
    chk("samecyc_old", {31'd0, mismatch}, 0);
    rd(3'd2, 16'h5555);
    chk("samecyc_new", {31'd0, mismatch}, 0);

    // Reset after 5 writes and 2 errors
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) wr(16'(16'h100 + i));
    rd(3'd1, 16'h0000);
    rd(3'd2, 16'h0000);
    chk("pre_rst_ec", {16'd0, error_count}, 2);
    cyc(1, 0, 0, 0, 0, 0);
    chk("rst_ec", {16'd0, error_count}, 0);
    chk("rst_wc", {16'd0, write_count}, 0);
    chk("rst_mis", {31'd0, mismatch}, 0);
    cyc(0, 1, 1, 16'hABCD, 3'd1, 16'h0000);
    rd(3'd0, 16'hABCD); chk("post_rst_ok", {31'd0, mismatch}, 0);
    rd(3'd0, 16'h0000);
    chk("post_rst_err", {31'd0, mismatch}, 1);
    chk("post_rst_exp", {16'd0, exp_data}, 32'hABCD);
    chk("post_rst_ptr", {29'd0, err_ptr}, 0);

    // Randomized phase
    for (int n = 0; n < 400; n++) begin
      logic [2:0] rp;
      rp = 3'($urandom_range(0, 7));
      cyc(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom), 16'($urandom), rp,
          ($urandom_range(0, 3) == 0) ? 16'($urandom) : cur(rp));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
